// File: rtl/logic_unit_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : logic_unit_pipe                                             |
// | Description : Three-way elastic join (lhs, rhs, opcode) feeding a         |
// |               bitwise AND/OR/XOR/XNOR unit, followed by NUM_STAGES        |
// |               elastic register stages with a combinational ready chain.   |
// |               Full throughput, configurable latency, absorbs backpressure.|
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
// | Ports                                                                     |
// |   clk                         : clock, rising edge                        |
// |   rst                         : asynchronous reset, active low            |
// |   lhs / lhs_valid / lhs_ready : left operand channel                      |
// |   rhs / rhs_valid / rhs_ready : right operand channel                     |
// |   op  / op_valid  / op_ready  : opcode channel (00 AND, 01 OR,            |
// |                                 10 XOR, 11 XNOR)                          |
// |   result / result_valid /     : output channel driven by the last stage   |
// |   result_ready                                                            |
// |   in_flight                   : number of occupied stages                 |
// +--------------------------------------------------------------------------+
module logic_unit_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_STAGES = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_WIDTH-1:0]             lhs,
    input  logic                              lhs_valid,
    output logic                              lhs_ready,
    input  logic [DATA_WIDTH-1:0]             rhs,
    input  logic                              rhs_valid,
    output logic                              rhs_ready,
    input  logic [1:0]                        op,
    input  logic                              op_valid,
    output logic                              op_ready,
    output logic [DATA_WIDTH-1:0]             result,
    output logic                              result_valid,
    input  logic                              result_ready,
    output logic [$clog2(NUM_STAGES+1)-1:0]   in_flight
);

    localparam int                 c_cnt_w   = $clog2(NUM_STAGES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    localparam logic [1:0] c_op_and  = 2'b00;
    localparam logic [1:0] c_op_or   = 2'b01;
    localparam logic [1:0] c_op_xor  = 2'b10;

    logic [NUM_STAGES-1:0]  r_v;
    logic [DATA_WIDTH-1:0]  r_d [NUM_STAGES];
    logic [c_cnt_w-1:0]     r_cnt;

    logic [NUM_STAGES:0]    w_adv;
    logic                   w_fire;
    logic                   w_out_hs;
    logic [DATA_WIDTH-1:0]  w_calc;

    // Ready chain: a stage may advance if it is empty or the stage after it
    // advances. Evaluated back-to-front through a scalar carry so every bit of
    // w_adv is written exactly once without reading itself.
    always_comb begin : p_adv
        logic v_chain;
        v_chain            = result_ready;
        w_adv              = '0;
        w_adv[NUM_STAGES]  = result_ready;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            v_chain  = ~r_v[i] | v_chain;
            w_adv[i] = v_chain;
        end
    end

    // Each ready depends only on the other two valids, so no channel sees a
    // combinational path from its own valid to its own ready.
    assign w_fire    = lhs_valid & rhs_valid & op_valid & w_adv[0];
    assign lhs_ready = rhs_valid & op_valid  & w_adv[0];
    assign rhs_ready = lhs_valid & op_valid  & w_adv[0];
    assign op_ready  = lhs_valid & rhs_valid & w_adv[0];

    always_comb begin : p_calc
        w_calc = '0;
        case (op)
            c_op_and: w_calc = lhs & rhs;
            c_op_or:  w_calc = lhs | rhs;
            c_op_xor: w_calc = lhs ^ rhs;
            default:  w_calc = ~(lhs ^ rhs);
        endcase
    end

    // Stage registers. Data only loads alongside a valid token so empty
    // stages keep their contents, and a stalled last stage holds result.
    always_ff @(posedge clk or negedge rst) begin : p_stages
        if (!rst) begin
            r_v <= '0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                r_d[i] <= '0;
            end
        end else begin
            if (w_adv[0]) begin
                r_v[0] <= w_fire;
                if (w_fire) begin
                    r_d[0] <= w_calc;
                end
            end
            for (int i = 1; i < NUM_STAGES; i++) begin
                if (w_adv[i]) begin
                    r_v[i] <= r_v[i-1];
                    if (r_v[i-1]) begin
                        r_d[i] <= r_d[i-1];
                    end
                end
            end
        end
    end

    assign w_out_hs = r_v[NUM_STAGES-1] & result_ready;

    // Occupancy: a simultaneous fire and drain leave the count unchanged.
    always_ff @(posedge clk or negedge rst) begin : p_cnt
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_fire && !w_out_hs) begin
            r_cnt <= r_cnt + c_cnt_one;
        end else if (w_out_hs && !w_fire) begin
            r_cnt <= r_cnt - c_cnt_one;
        end
    end

    assign result       = r_d[NUM_STAGES-1];
    assign result_valid = r_v[NUM_STAGES-1];
    assign in_flight    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_logic_unit_pipe                                          |
// | Description : Scoreboard bench for logic_unit_pipe. Four instances with   |
// |               different widths/depths share clock and reset; a reference  |
// |               model tracks each accepted token's value and age.           |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_logic_unit_pipe;

    localparam int c_n_dut = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    logic [63:0] lhs [c_n_dut];
    logic [63:0] rhs [c_n_dut];
    logic [1:0]  op  [c_n_dut];
    logic [c_n_dut-1:0] lhs_valid, rhs_valid, op_valid, result_ready;
    logic [c_n_dut-1:0] lhs_ready, rhs_ready, op_ready, result_valid;

    logic [31:0] res0;
    logic [7:0]  res1;
    logic [63:0] res2;
    logic [0:0]  res3;
    logic [1:0]  inf0;
    logic [2:0]  inf1;
    logic [1:0]  inf2;
    logic [0:0]  inf3;

    logic [63:0] res_x [c_n_dut];
    int          inf_x [c_n_dut];

    always_comb begin
        res_x[0] = 64'(res0);
        res_x[1] = 64'(res1);
        res_x[2] = 64'(res2);
        res_x[3] = 64'(res3);
        inf_x[0] = int'(inf0);
        inf_x[1] = int'(inf1);
        inf_x[2] = int'(inf2);
        inf_x[3] = int'(inf3);
    end

    logic_unit_pipe #(.DATA_WIDTH(32), .NUM_STAGES(2)) u_dut0 (
        .clk(clk), .rst(rst),
        .lhs(lhs[0][31:0]), .lhs_valid(lhs_valid[0]), .lhs_ready(lhs_ready[0]),
        .rhs(rhs[0][31:0]), .rhs_valid(rhs_valid[0]), .rhs_ready(rhs_ready[0]),
        .op(op[0]), .op_valid(op_valid[0]), .op_ready(op_ready[0]),
        .result(res0), .result_valid(result_valid[0]), .result_ready(result_ready[0]),
        .in_flight(inf0)
    );

    logic_unit_pipe #(.DATA_WIDTH(8), .NUM_STAGES(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .lhs(lhs[1][7:0]), .lhs_valid(lhs_valid[1]), .lhs_ready(lhs_ready[1]),
        .rhs(rhs[1][7:0]), .rhs_valid(rhs_valid[1]), .rhs_ready(rhs_ready[1]),
        .op(op[1]), .op_valid(op_valid[1]), .op_ready(op_ready[1]),
        .result(res1), .result_valid(result_valid[1]), .result_ready(result_ready[1]),
        .in_flight(inf1)
    );

    logic_unit_pipe #(.DATA_WIDTH(64), .NUM_STAGES(3)) u_dut2 (
        .clk(clk), .rst(rst),
        .lhs(lhs[2]), .lhs_valid(lhs_valid[2]), .lhs_ready(lhs_ready[2]),
        .rhs(rhs[2]), .rhs_valid(rhs_valid[2]), .rhs_ready(rhs_ready[2]),
        .op(op[2]), .op_valid(op_valid[2]), .op_ready(op_ready[2]),
        .result(res2), .result_valid(result_valid[2]), .result_ready(result_ready[2]),
        .in_flight(inf2)
    );

    logic_unit_pipe #(.DATA_WIDTH(1), .NUM_STAGES(1)) u_dut3 (
        .clk(clk), .rst(rst),
        .lhs(lhs[3][0:0]), .lhs_valid(lhs_valid[3]), .lhs_ready(lhs_ready[3]),
        .rhs(rhs[3][0:0]), .rhs_valid(rhs_valid[3]), .rhs_ready(rhs_ready[3]),
        .op(op[3]), .op_valid(op_valid[3]), .op_ready(op_ready[3]),
        .result(res3), .result_valid(result_valid[3]), .result_ready(result_ready[3]),
        .in_flight(inf3)
    );

    function automatic int ns_of(input int k);
        case (k)
            0:       return 2;
            1:       return 4;
            2:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic logic [63:0] mask_of(input int k);
        case (k)
            0:       return 64'h0000_0000_FFFF_FFFF;
            1:       return 64'h0000_0000_0000_00FF;
            2:       return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return 64'h0000_0000_0000_0001;
        endcase
    endfunction

    function automatic logic [63:0] ref_op(input logic [63:0] a, input logic [63:0] b,
                                           input logic [1:0] o);
        case (o)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a ^ b);
        endcase
    endfunction

    // Reference model: per instance, an ordered list of accepted tokens with
    // the number of edges each has spent inside the pipe. A token is visible
    // at the output once it is the oldest and has aged NUM_STAGES edges; the
    // pipe can accept whenever it is not full or the output is draining.
    logic [63:0] sb_val [c_n_dut][8];
    int          sb_age [c_n_dut][8];
    int          sb_sz  [c_n_dut];

    int checks = 0;
    int errors = 0;

    logic m_ev, m_acc, m_fire;

    task automatic chk(input string name, input int k,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%h required=%h t=%0t", name, k, act, exp, $time);
        end
    endtask

    always begin : p_monitor
        @(negedge clk or negedge rst);
        if (!rst) begin
            for (int k = 0; k < c_n_dut; k++) sb_sz[k] = 0;
            #1;
            for (int k = 0; k < c_n_dut; k++) begin
                chk("rst_result_valid", k, 64'(result_valid[k]), 64'd0);
                chk("rst_result",       k, res_x[k],             64'd0);
                chk("rst_in_flight",    k, 64'(inf_x[k]),        64'd0);
            end
        end else begin
            for (int k = 0; k < c_n_dut; k++) begin
                m_ev  = (sb_sz[k] > 0) && (sb_age[k][0] >= ns_of(k));
                m_acc = (sb_sz[k] < ns_of(k)) || result_ready[k];
                chk("result_valid", k, 64'(result_valid[k]), 64'(m_ev));
                if (m_ev) chk("result", k, res_x[k], sb_val[k][0]);
                chk("in_flight", k, 64'(inf_x[k]), 64'(sb_sz[k]));
                chk("in_flight_bound", k, 64'(inf_x[k] <= ns_of(k)), 64'd1);
                chk("lhs_ready", k, 64'(lhs_ready[k]), 64'(rhs_valid[k] & op_valid[k] & m_acc));
                chk("rhs_ready", k, 64'(rhs_ready[k]), 64'(lhs_valid[k] & op_valid[k] & m_acc));
                chk("op_ready",  k, 64'(op_ready[k]),  64'(lhs_valid[k] & rhs_valid[k] & m_acc));
                if (m_ev && result_ready[k]) begin
                    for (int j = 0; j < 7; j++) begin
                        sb_val[k][j] = sb_val[k][j+1];
                        sb_age[k][j] = sb_age[k][j+1];
                    end
                    sb_sz[k]--;
                end
                m_fire = lhs_valid[k] & rhs_valid[k] & op_valid[k] & m_acc;
                if (m_fire) begin
                    sb_val[k][sb_sz[k]] = ref_op(lhs[k], rhs[k], op[k]) & mask_of(k);
                    sb_age[k][sb_sz[k]] = 0;
                    sb_sz[k]++;
                end
                for (int j = 0; j < sb_sz[k]; j++) sb_age[k][j]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_inputs(input int k, input bit stall_ok);
        lhs[k]          = {$urandom, $urandom};
        rhs[k]          = {$urandom, $urandom};
        op[k]           = 2'($urandom);
        lhs_valid[k]    = ($urandom_range(0, 3) != 0);
        rhs_valid[k]    = ($urandom_range(0, 3) != 0);
        op_valid[k]     = ($urandom_range(0, 3) != 0);
        result_ready[k] = stall_ok ? ($urandom_range(0, 2) != 0) : 1'b1;
    endtask

    task automatic idle_all();
        lhs_valid    = '0;
        rhs_valid    = '0;
        op_valid     = '0;
        result_ready = '1;
    endtask

    initial begin : p_stim
        for (int k = 0; k < c_n_dut; k++) begin
            lhs[k]   = '0;
            rhs[k]   = '0;
            op[k]    = '0;
            sb_sz[k] = 0;
            for (int j = 0; j < 8; j++) begin
                sb_val[k][j] = '0;
                sb_age[k][j] = 0;
            end
        end
        // Reset held with every valid asserted.
        lhs_valid    = '1;
        rhs_valid    = '1;
        op_valid     = '1;
        result_ready = '1;
        lhs[0] = 64'hF0F0_1234;
        rhs[0] = 64'hFF00_00FF;
        op[0]  = 2'b00;
        repeat (3) tick();

        // Release: opcodes 00..11 fire on consecutive cycles on instance 0.
        rst = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            op[0] = 2'(i);
        end
        tick();
        idle_all();
        repeat (5) tick();

        // Partial join: rhs missing for five cycles, then supplied for one.
        lhs_valid[0] = 1'b1;
        op_valid[0]  = 1'b1;
        lhs[0] = 64'h1234_5678;
        rhs[0] = 64'h0F0F_0F0F;
        op[0]  = 2'b10;
        repeat (5) tick();
        rhs_valid[0] = 1'b1;
        tick();
        idle_all();
        repeat (4) tick();

        // Backpressure: five offered tokens against a stalled output.
        result_ready[0] = 1'b0;
        lhs_valid[0] = 1'b1;
        rhs_valid[0] = 1'b1;
        op_valid[0]  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            lhs[0] = {$urandom, $urandom};
            rhs[0] = {$urandom, $urandom};
            op[0]  = 2'($urandom);
            tick();
        end
        // Release and keep streaming to see the drain and full throughput.
        result_ready[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lhs[0] = {$urandom, $urandom};
            rhs[0] = {$urandom, $urandom};
            op[0]  = 2'($urandom);
            tick();
        end
        idle_all();
        repeat (5) tick();

        // Random traffic on every instance.
        repeat (2000) begin
            for (int k = 0; k < c_n_dut; k++) randomize_inputs(k, 1'b1);
            tick();
        end
        idle_all();
        repeat (6) tick();

        // Mid-flight reset: three tokens parked in the 4-stage instance.
        result_ready = '0;
        lhs_valid[1] = 1'b1;
        rhs_valid[1] = 1'b1;
        op_valid[1]  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lhs[1] = {$urandom, $urandom};
            rhs[1] = {$urandom, $urandom};
            op[1]  = 2'($urandom);
            tick();
        end
        lhs_valid = '0;
        rhs_valid = '0;
        op_valid  = '0;
        tick();
        @(posedge clk);
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        result_ready = '1;
        repeat (10) tick();

        repeat (300) begin
            for (int k = 0; k < c_n_dut; k++) randomize_inputs(k, 1'b1);
            tick();
        end
        idle_all();
        repeat (8) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
